cline_arb: RTL and testbench
============================

CLINE_ARB -- requirements
Module: cline_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of cacheline requester channels (2..8).
REQ-002 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port ch_addr  input  NUM_CH x ADDR_W  per-channel line address.
REQ-007 SHALL have port ch_read  input  NUM_CH  per-channel read request, held until ch_resp.
REQ-008 SHALL have port ch_write  input  NUM_CH  per-channel write request, held until ch_resp.
REQ-009 SHALL have port ch_wdata  input  NUM_CH x LINE_W  per-channel write line.
REQ-010 SHALL have port ch_rdata  output  NUM_CH x LINE_W  per-channel read line, valid with ch_resp.
REQ-011 SHALL have port ch_resp  output  NUM_CH  per-channel one-cycle completion pulse.
REQ-012 SHALL have port pmem_address  output  ADDR_W  address to physical memory.
REQ-013 SHALL have port pmem_wdata  output  LINE_W  write line to physical memory.
REQ-014 SHALL have port pmem_read  output  1  memory read strobe, held until pmem_resp.
REQ-015 SHALL have port pmem_write  output  1  memory write strobe, held until pmem_resp.
REQ-016 SHALL have port pmem_rdata  input  LINE_W  memory read line, valid with pmem_resp.
REQ-017 SHALL have port pmem_resp  input  1  memory completion.

Function
REQ-018 SHALL implement FSM IDLE -> MEM -> DONE -> IDLE.
REQ-019 IDLE: if any ch_read|ch_write, pick grant g per REQ-026/027, latch g, address, wdata, op; go MEM next edge; else stay.
REQ-020 MEM: pmem_read or pmem_write (per latched op) high, pmem_address/pmem_wdata from latches, all stable every cycle until pmem_resp.
REQ-021 MEM with pmem_resp: capture pmem_rdata into ch_rdata[g]; go DONE; pmem strobes low from next cycle.
REQ-022 DONE: ch_resp[g]=1 for exactly one cycle, all other ch_resp=0; go IDLE unconditionally.
REQ-023 Minimum request-to-resp latency SHALL be 3 cycles with pmem_resp in first MEM cycle; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-024 Channel asserting both ch_read and ch_write SHALL be serviced as write; ch_rdata unchanged.
REQ-025 Requests arriving or changing while MEM/DONE SHALL be ignored until next IDLE; ch_rdata[i] SHALL hold last value between responses.
REQ-026 (ARB_RR_EN defined) grant SHALL be first requesting channel searching upward from (last_grant+1) mod NUM_CH with wrap.
REQ-027 (ARB_RR_EN undefined) grant SHALL be lowest-index requesting channel.
REQ-028 pmem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-029 On rst: state=IDLE, pmem_read=0, pmem_write=0, all ch_resp=0, pmem_address=0, pmem_wdata=0, ch_rdata all 0, last_grant=NUM_CH-1 (so channel 0 searched first).
REQ-030 rst mid-MEM SHALL abort transaction; no ch_resp issued; late pmem_resp ignored.

Configuration
REQ-031 Macro ARB_RR_EN: defined -> round-robin per REQ-026 with last_grant register; undefined -> fixed priority per REQ-027, no last_grant register.

Structure
REQ-032 Package rv32i_types SHALL hold cline_arb_state_t enum (IDLE, MEM, DONE) and default LINE_W/ADDR_W constants.
REQ-033 Grant selection SHALL be sub-module rr_picker (inputs req vector, last_grant; outputs grant index, any_req), purely combinational.

Verification
REQ-034 Single read ch1 addr 0x0000_1000, pmem_resp after 4 cycles with data 0xA5..A5 -> pmem_read held 4 cycles, ch_resp[1] one cycle, ch_rdata[1]=0xA5..A5.
REQ-035 ch0 and ch1 read simultaneously, held, ARB_RR_EN defined -> grants 0,1,0,1 on repeated requests; undefined -> ch0 always first.
REQ-036 Write ch0 addr 0x40 wdata 0x1234.. -> pmem_write=1, pmem_address=0x40, pmem_wdata=0x1234.., ch_rdata[0] unchanged.
REQ-037 rst asserted in second MEM cycle, pmem_resp next cycle -> no ch_resp, pmem strobes 0, state IDLE.
REQ-038 NUM_CH=4, channels 1 and 3 requesting, last_grant=3 -> grant 1, then 3 (RR); ch_read+ch_write on ch2 -> write issued.

Source files
------------

// File: rtl/cline_arb_pkg.sv
// Shared types, width defaults and helpers for the cacheline arbiter.
// The round-robin policy is selected with the ARB_RR_EN macro (see cline_arb).
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } cline_arb_state_t;

  localparam int CLINE_LINE_W = 256;
  localparam int CLINE_ADDR_W = 32;

  // Channel index reached by stepping 'off' places up from 'base', wrapping at n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end else begin
      sum = sum;
    end
    return sum;
  endfunction

endpackage

// File: rtl/cline_arb_rr_picker.sv
// Combinational grant picker: first requester searching upward from last_grant+1.
// A last_grant of NUM_CH-1 makes it a lowest-index-first priority encoder.
module rr_picker import rv32i_types::*; #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  grant,
  output logic              any_req
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Scan every channel once in wrap order and keep the first hit.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand_s  = IDX_W'(wrap_idx(int'(last_grant), off, NUM_CH));
      hit_s   = req[cand_s] & ~any_req;
      grant   = hit_s ? cand_s : grant;
      any_req = any_req | req[cand_s];
    end
  end

endmodule

// File: rtl/cline_arb.sv
// Cacheline arbiter: serialises NUM_CH read/write requesters onto one memory port.
// Define ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module cline_arb import rv32i_types::*; #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = CLINE_LINE_W,
  parameter int ADDR_W = CLINE_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [NUM_CH*LINE_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  input  logic [LINE_W-1:0]          pmem_rdata,
  input  logic                       pmem_resp
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  cline_arb_state_t state_r;
  cline_arb_state_t state_nxt;

  logic [NUM_CH-1:0] req_s;
  logic [IDX_W-1:0]  pick_s;
  logic [IDX_W-1:0]  grant_r;
  logic [IDX_W-1:0]  last_grant_s;
  logic              any_req_s;

  assign req_s = ch_read | ch_write;

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] last_grant_r;

  // Remember the most recent grant so the next search starts just above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= IDX_W'(NUM_CH - 1);
    end else if ((state_r == IDLE) && any_req_s) begin
      last_grant_r <= pick_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = IDX_W'(NUM_CH - 1);
`endif

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req        (req_s),
    .last_grant (last_grant_s),
    .grant      (pick_s),
    .any_req    (any_req_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode; pmem_resp only matters while a transaction is in MEM.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt = MEM;
        end else begin
          state_nxt = IDLE;
        end
      end
      MEM: begin
        if (pmem_resp) begin
          state_nxt = DONE;
        end else begin
          state_nxt = MEM;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latches, memory strobes and per-channel completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      ch_resp      <= '0;
      ch_rdata     <= '0;
    end else begin
      ch_resp <= '0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r      <= pick_s;
            pmem_address <= ch_addr[pick_s*ADDR_W +: ADDR_W];
            pmem_wdata   <= ch_wdata[pick_s*LINE_W +: LINE_W];
            // A channel raising both strobes is treated as a write.
            pmem_write   <= ch_write[pick_s];
            pmem_read    <= ~ch_write[pick_s];
          end else begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
          end
        end
        MEM: begin
          if (pmem_resp) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            ch_resp[grant_r] <= 1'b1;
            if (!pmem_write) begin
              ch_rdata[grant_r*LINE_W +: LINE_W] <= pmem_rdata;
            end else begin
              ch_rdata[grant_r*LINE_W +: LINE_W] <= ch_rdata[grant_r*LINE_W +: LINE_W];
            end
          end else begin
            pmem_read  <= pmem_read;
            pmem_write <= pmem_write;
          end
        end
        DONE: begin
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
        default: begin
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cline_arb.sv
// Scoreboard bench for cline_arb (NUM_CH=4, LINE_W=64): expected memory and
// channel transactions are queued by the stimulus and checked by monitors.
module tb_cline_arb;

  localparam int NCH = 4;
  localparam int LW  = 64;
  localparam int AW  = 32;

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic [63:0] rdata;
    logic [63:0] exp_rdata;
    int          exp_lat;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH-1:0]    ch_read = '0;
  logic [NCH-1:0]    ch_write = '0;
  logic [NCH*LW-1:0] ch_wdata = '0;
  logic [NCH*LW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_resp;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [LW-1:0]     pmem_rdata = '0;
  logic              pmem_resp;
  logic              model_resp = 1'b0;
  logic              inj_resp = 1'b0;
  logic              model_en = 1'b1;

  assign pmem_resp = model_resp | inj_resp;

  cline_arb #(.NUM_CH(NCH), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_addr      (ch_addr),
    .ch_read      (ch_read),
    .ch_write     (ch_write),
    .ch_wdata     (ch_wdata),
    .ch_rdata     (ch_rdata),
    .ch_resp      (ch_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          want[NCH] = '{default: 0};
  int          done[NCH] = '{default: 0};
  int          drive_cyc[NCH] = '{default: 0};
  bit          rd_a[NCH] = '{default: 1'b0};
  bit          wr_a[NCH] = '{default: 1'b0};
  logic [31:0] addr_a[NCH] = '{default: 32'h0};
  logic [63:0] wdata_a[NCH] = '{default: 64'h0};
  logic [63:0] rdm[NCH] = '{default: 64'h0};

  txn_t mem_q[$];
  txn_t resp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: each channel holds its request until it has seen want[i] responses.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) done[i] = 0;
      else if (ch_resp[i]) done[i] = done[i] + 1;
      if (done[i] < want[i]) begin
        if (!ch_read[i] && !ch_write[i]) drive_cyc[i] = cyc;
        ch_read[i]  = rd_a[i];
        ch_write[i] = wr_a[i];
      end else begin
        ch_read[i]  = 1'b0;
        ch_write[i] = 1'b0;
      end
      ch_addr[i*AW +: AW]  = addr_a[i];
      ch_wdata[i*LW +: LW] = wdata_a[i];
    end
  end

  // Memory model: checks each issued transaction, then answers after its latency.
  txn_t cur;
  bit   active = 1'b0;
  int   cnt = 0;
  always @(negedge clk) begin
    if (rst || !model_en) begin
      active     = 1'b0;
      model_resp = 1'b0;
    end else if (model_resp) begin
      model_resp = 1'b0;
      check("strobe_drop", {62'd0, pmem_read, pmem_write}, 64'd0);
    end else if (pmem_read || pmem_write) begin
      if (!active) begin
        if (mem_q.size() == 0) begin
          check("unexpected_pmem", {62'd0, pmem_read, pmem_write}, 64'd0);
        end else begin
          cur = mem_q.pop_front();
          check("pmem_op_write", {63'd0, pmem_write}, {63'd0, cur.wr});
          check("pmem_op_read", {63'd0, pmem_read}, {63'd0, !cur.wr});
          check("pmem_address", {32'd0, pmem_address}, {32'd0, cur.addr});
          if (cur.wr) check("pmem_wdata", pmem_wdata, cur.wdata);
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        check("pmem_addr_stable", {32'd0, pmem_address}, {32'd0, cur.addr});
        check("pmem_strobe_stable", {62'd0, pmem_read, pmem_write}, {62'd0, !cur.wr, cur.wr});
      end
      if (active) begin
        cnt = cnt + 1;
        if (cnt == cur.lat) begin
          model_resp = 1'b1;
          pmem_rdata = cur.rdata;
          active     = 1'b0;
        end
      end
    end
  end

  // Response monitor: every ch_resp pulse must match the next expected completion.
  txn_t rt;
  always @(negedge clk) begin
    if (ch_resp != '0) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", {60'd0, ch_resp}, 64'd0);
      end else begin
        rt = resp_q.pop_front();
        check("resp_onehot", {60'd0, ch_resp}, 64'd1 << rt.ch);
        check("resp_rdata", ch_rdata[rt.ch*LW +: LW], rt.exp_rdata);
        if (rt.exp_lat >= 0) check("resp_latency", 64'(cyc - drive_cyc[rt.ch]), 64'(rt.exp_lat));
      end
    end
  end

  task automatic push(input int ch, input int lat, input logic [63:0] rdata, input int exp_lat);
    txn_t t;
    t.ch        = ch;
    t.wr        = wr_a[ch];
    t.addr      = addr_a[ch];
    t.wdata     = wdata_a[ch];
    t.lat       = lat;
    t.rdata     = rdata;
    t.exp_rdata = t.wr ? rdm[ch] : rdata;
    t.exp_lat   = exp_lat;
    rdm[ch]     = t.exp_rdata;
    mem_q.push_back(t);
    resp_q.push_back(t);
  endtask

  task automatic set_ch(input int ch, input bit rd, input bit wr, input logic [31:0] a, input logic [63:0] wd);
    rd_a[ch]    = rd;
    wr_a[ch]    = wr;
    addr_a[ch]  = a;
    wdata_a[ch] = wd;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      want[i] = 0;
      rdm[i]  = 64'h0;
    end
    mem_q.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (mem_q.size() == 0 && resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({"timeout_", name}, 64'(resp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset_dut();
    @(negedge clk);
    check("rst_pmem_read", {63'd0, pmem_read}, 64'd0);
    check("rst_pmem_write", {63'd0, pmem_write}, 64'd0);
    check("rst_ch_resp", {60'd0, ch_resp}, 64'd0);
    check("rst_pmem_address", {32'd0, pmem_address}, 64'd0);
    check("rst_pmem_wdata", pmem_wdata, 64'd0);
    check("rst_ch_rdata", 64'(ch_rdata != '0), 64'd0);
    @(posedge clk); #1;

    // Single read ch1, four MEM cycles, then minimum-latency read on ch3
    set_ch(1, 1'b1, 1'b0, 32'h0000_1000, 64'h0);
    push(1, 4, {8{8'hA5}}, 5);
    want[1] = 1;
    wait_idle("read_ch1");
    set_ch(3, 1'b1, 1'b0, 32'h0000_2000, 64'h0);
    push(3, 1, 64'h0123_4567_89AB_CDEF, 2);
    want[3] = 1;
    wait_idle("read_ch3_min");
    check("hold_ch1_rdata", ch_rdata[1*LW +: LW], {8{8'hA5}});

    // Read then write on ch0: the write must leave ch_rdata[0] alone
    reset_dut();
    set_ch(0, 1'b1, 1'b0, 32'h0000_0080, 64'h0);
    push(0, 2, 64'hDEAD_BEEF_CAFE_F00D, 3);
    want[0] = 1;
    wait_idle("read_ch0");
    set_ch(0, 1'b0, 1'b1, 32'h0000_0040, 64'h1234_5678_9ABC_DEF0);
    push(0, 3, 64'hFFFF_0000_FFFF_0000, -1);
    want[0] = 2;
    wait_idle("write_ch0");
    check("write_keeps_rdata", ch_rdata[0*LW +: LW], 64'hDEAD_BEEF_CAFE_F00D);

    // ch0 and ch1 both requesting twice
    reset_dut();
    set_ch(0, 1'b1, 1'b0, 32'h0000_0100, 64'h0);
    set_ch(1, 1'b1, 1'b0, 32'h0000_0200, 64'h0);
`ifdef ARB_RR_EN
    push(0, 2, 64'hD0D0_0000_0000_000A, -1);
    push(1, 1, 64'hD1D1_0000_0000_000A, -1);
    push(0, 2, 64'hD0D0_0000_0000_000B, -1);
    push(1, 1, 64'hD1D1_0000_0000_000B, -1);
`else
    push(0, 2, 64'hD0D0_0000_0000_000A, -1);
    push(0, 2, 64'hD0D0_0000_0000_000B, -1);
    push(1, 1, 64'hD1D1_0000_0000_000A, -1);
    push(1, 1, 64'hD1D1_0000_0000_000B, -1);
`endif
    want[0] = 2;
    want[1] = 2;
    wait_idle("contend_01");
    check("final_ch0_rdata", ch_rdata[0*LW +: LW], 64'hD0D0_0000_0000_000B);
    check("final_ch1_rdata", ch_rdata[1*LW +: LW], 64'hD1D1_0000_0000_000B);

    // Channels 1 and 3 from reset, then read+write on ch2
    reset_dut();
    set_ch(1, 1'b1, 1'b0, 32'h0000_1100, 64'h0);
    set_ch(3, 1'b0, 1'b1, 32'h0000_3300, 64'h3333_3333_3333_3333);
`ifdef ARB_RR_EN
    push(1, 1, 64'h1111_1111_1111_1111, -1);
    push(3, 2, 64'hBAD0_BAD0_BAD0_BAD0, -1);
    push(1, 1, 64'h1111_2222_1111_2222, -1);
`else
    push(1, 1, 64'h1111_1111_1111_1111, -1);
    push(1, 1, 64'h1111_2222_1111_2222, -1);
    push(3, 2, 64'hBAD0_BAD0_BAD0_BAD0, -1);
`endif
    want[1] = 2;
    want[3] = 1;
    wait_idle("contend_13");
    set_ch(2, 1'b1, 1'b1, 32'h0000_2200, 64'h2222_2222_2222_2222);
    push(2, 2, 64'hBAD2_BAD2_BAD2_BAD2, 3);
    want[2] = 1;
    wait_idle("rw_ch2");
    check("rw_keeps_ch2_rdata", ch_rdata[2*LW +: LW], 64'h0);

    // Reset in the second MEM cycle, stray pmem_resp afterwards
    reset_dut();
    model_en = 1'b0;
    set_ch(0, 1'b1, 1'b0, 32'h0000_0300, 64'h0);
    want[0] = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read) break;
    end
    check("abort_enter_mem", {63'd0, pmem_read}, 64'd1);
    @(negedge clk);
    check("abort_second_mem", {63'd0, pmem_read}, 64'd1);
    rst = 1'b1;
    want[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    inj_resp = 1'b1;
    @(negedge clk);
    inj_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_no_resp", {60'd0, ch_resp}, 64'd0);
      check("abort_strobes", {62'd0, pmem_read, pmem_write}, 64'd0);
      @(negedge clk);
    end
    check("abort_rdata", 64'(ch_rdata != '0), 64'd0);
    model_en = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
